// File: rtl/floo_route_encoder_pkg.sv
// rtl/floo_route_encoder_pkg.sv - shared types and constants for the route encoder
// Default flit/rule layouts; the top module takes them as overridable type parameters.
package floo_route_encoder_pkg;

  typedef enum logic [1:0] {
    IdIsPort,
    SourceRouting,
    XYRouting,
    IdTable
  } route_algo_e;

  typedef enum logic [0:0] {
    HEAD,
    BODY
  } enc_state_e;

  localparam int unsigned DefaultNumDst   = 4;
  localparam int unsigned DefaultIdxWidth = $clog2(DefaultNumDst);
  localparam int unsigned DefaultIdWidth  = 8;
  localparam int unsigned DefaultLenWidth = 8;

  typedef logic [47:0] enc_addr_t;
  typedef logic [31:0] enc_payload_t;

  typedef struct packed {
    logic [DefaultIdxWidth-1:0] idx;
    enc_addr_t                  start_addr;
    enc_addr_t                  end_addr;
  } enc_addr_rule_t;

  typedef struct packed {
    logic [DefaultIdWidth-1:0] dst_id;
    logic [DefaultIdWidth-1:0] src_id;
    logic                      last;
  } enc_hdr_t;

  typedef struct packed {
    enc_hdr_t     hdr;
    enc_payload_t payload;
  } enc_flit_t;

endpackage

// File: rtl/floo_route_encoder_if.sv
// rtl/floo_route_encoder_if.sv - beat-in / flit-out handshake bundle of the route encoder
// Signal suffixes are from the encoder's point of view; the encoder uses the slave modport.
interface floo_route_encoder_if
  import floo_route_encoder_pkg::*;
#(
  parameter int unsigned LenWidth  = DefaultLenWidth,
  parameter type         addr_t    = enc_addr_t,
  parameter type         payload_t = enc_payload_t,
  parameter type         flit_t    = enc_flit_t
);

  logic                valid_i;
  logic                ready_o;
  addr_t               addr_i;
  logic [LenWidth-1:0] len_i;
  payload_t            payload_i;

  logic                valid_o;
  logic                ready_i;
  flit_t               flit_o;
  logic                dec_error_o;

  modport master (
    output valid_i, addr_i, len_i, payload_i, ready_i,
    input  ready_o, valid_o, flit_o, dec_error_o
  );

  modport slave (
    input  valid_i, addr_i, len_i, payload_i, ready_i,
    output ready_o, valid_o, flit_o, dec_error_o
  );

endinterface

// File: rtl/floo_route_enc_reg.sv
// rtl/floo_route_enc_reg.sv - one-entry valid/ready output register with stable hold
// Full throughput: a new entry may be written in the same cycle the held one is popped.
module floo_route_enc_reg #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o
);

  logic  valid_q;
  data_t data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (valid_i && ready_o) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/floo_route_encoder.sv
// rtl/floo_route_encoder.sv - injection-side flit header builder with burst destination lock
// Optional SVA checks are compiled in when FLOO_ROUTE_ENC_ASSERT_EN is defined.
module floo_route_encoder
  import floo_route_encoder_pkg::*;
#(
  parameter route_algo_e RouteAlgo    = IdTable,
  parameter int unsigned NumDst       = DefaultNumDst,
  parameter int unsigned NumAddrRules = 4,
  parameter int unsigned IdWidth      = DefaultIdWidth,
  parameter int unsigned LenWidth     = DefaultLenWidth,
  parameter type         addr_t       = enc_addr_t,
  parameter type         addr_rule_t  = enc_addr_rule_t,
  parameter type         payload_t    = enc_payload_t,
  parameter type         flit_t       = enc_flit_t,
  localparam int unsigned IdxWidth    = (NumDst > 1) ? $clog2(NumDst) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           test_enable_i,
  input  logic [IdWidth-1:0]             src_id_i,
  input  addr_rule_t [NumAddrRules-1:0]  addr_map_i,
  input  logic [NumDst-1:0][IdWidth-1:0] dst_table_i,
  input  logic [IdxWidth-1:0]            default_idx_i,
  floo_route_encoder_if.slave            bus
);

  localparam logic [0:0] StHead = HEAD;
  localparam logic [0:0] StBody = BODY;

  if ((RouteAlgo != IdTable) && (RouteAlgo != XYRouting) &&
      (RouteAlgo != SourceRouting)) begin : gen_bad_algo
    $fatal(1, "floo_route_encoder: unsupported RouteAlgo");
  end

  logic                unused_test_enable;
  logic [0:0]          state_q, state_d;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic [IdWidth-1:0]  dst_q, dst_d;
  logic [IdWidth-1:0]  src_q, src_d;
  logic                err_q, err_d;
  logic                in_ready, accept, is_head;
  logic                dec_hit;
  logic [IdxWidth-1:0] dec_idx;
  logic [IdWidth-1:0]  head_dst;
  addr_t               beat_addr;
  payload_t            beat_payload;
  flit_t               flit_d;

  assign unused_test_enable = test_enable_i;
  assign beat_addr          = bus.addr_i;
  assign beat_payload       = bus.payload_i;
  assign accept             = bus.valid_i && in_ready;
  assign is_head            = (state_q == StHead);
  assign bus.ready_o        = in_ready;
  assign bus.dec_error_o    = err_q;

  // Descending scan so the lowest-numbered matching rule wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = default_idx_i;
    for (int i = int'(NumAddrRules) - 1; i >= 0; i--) begin
      if ((beat_addr >= addr_map_i[i].start_addr) && (beat_addr < addr_map_i[i].end_addr)) begin
        dec_hit = 1'b1;
        dec_idx = addr_map_i[i].idx;
      end
    end
  end

  assign head_dst = dst_table_i[dec_idx];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dst_d          = dst_q;
    src_d          = src_q;
    err_d          = 1'b0;
    flit_d         = '0;
    flit_d.payload = beat_payload;
    if (is_head) begin
      flit_d.hdr.dst_id = head_dst;
      flit_d.hdr.src_id = src_id_i;
      flit_d.hdr.last   = (bus.len_i == '0);
    end else begin
      flit_d.hdr.dst_id = dst_q;
      flit_d.hdr.src_id = src_q;
      flit_d.hdr.last   = (cnt_q == LenWidth'(1));
    end
    if (accept) begin
      if (is_head) begin
        dst_d = head_dst;
        src_d = src_id_i;
        err_d = !dec_hit;
        if (bus.len_i != '0) begin
          cnt_d   = bus.len_i;
          state_d = StBody;
        end
      end else begin
        cnt_d = cnt_q - LenWidth'(1);
        if (cnt_q == LenWidth'(1)) begin
          state_d = StHead;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StHead;
      cnt_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  floo_route_enc_reg #(
    .data_t (flit_t)
  ) i_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (bus.valid_i),
    .ready_o (in_ready),
    .data_i  (flit_d),
    .valid_o (bus.valid_o),
    .ready_i (bus.ready_i),
    .data_o  (bus.flit_o)
  );

`ifdef FLOO_ROUTE_ENC_ASSERT_EN
  logic                chk_open_q;
  logic [IdWidth-1:0]  chk_dst_q;
  logic [LenWidth-1:0] chk_len_q;
  logic [LenWidth-1:0] chk_beat_q;
  logic                pop;

  assign pop = bus.valid_o && bus.ready_i;

  // Output-side burst tracker and input-side beat index, independent of the FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_open_q <= 1'b0;
      chk_dst_q  <= '0;
      chk_len_q  <= '0;
      chk_beat_q <= '0;
    end else begin
      if (pop) begin
        chk_open_q <= !bus.flit_o.hdr.last;
        chk_dst_q  <= bus.flit_o.hdr.dst_id;
      end
      if (accept) begin
        chk_len_q  <= is_head ? bus.len_i : chk_len_q;
        chk_beat_q <= is_head ? LenWidth'(1) : chk_beat_q + LenWidth'(1);
      end
    end
  end

  a_flit_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.valid_o && !bus.ready_i) |=> $stable(bus.flit_o));

  a_dst_locked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop && chk_open_q) |-> (bus.flit_o.hdr.dst_id == chk_dst_q));

  a_burst_len: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (accept && !is_head) |-> (flit_d.hdr.last == (chk_beat_q == chk_len_q)));

  a_no_err_in_body: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (accept && !is_head) |=> !bus.dec_error_o);
`else
  // Assertions not compiled in this build.
`endif

endmodule
